arm_shift_pipe: RTL and testbench
=================================

# arm_shift_pipe

Parametrised, pipelined ARM-style barrel shifter for the execute datapath. It generalises the fixed 32-bit immediate rotator to a configurable width and adds all five ARMv4 shift types plus the immediate-rotate mode, with correct shifter carry-out. A valid/ready elastic pipeline of configurable depth sits between the operand-read stage and the ALU, with throughput of one operation per cycle.

## Interface
- WIDTH, 32: datapath width; power of two, at least 8.
- STAGES, 2: pipeline register stages, 1..4; this is the latency in cycles.
- AMT_W, 8: shift-amount width; the ARM register-specified shift uses Rs[7:0].
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low; clears all stage valids.
- flush  in  1  synchronous; drops every in-flight operation.
- in_valid  in  1  operand/command valid.
- in_ready  out  1  pipeline can accept this cycle.
- op  in  3  operation: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5 IMMROT; 6 and 7 are reserved.
- a  in  WIDTH  operand.
- amount  in  AMT_W  shift amount; IMMROT uses only amount[3:0].
- carry_in  in  1  current C flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- result  out  WIDTH  shifted value.
- carry_out  out  1  shifter carry.

## Operation
- Let n = amount and W = WIDTH.
- LSL:
  - n=0: result = a, carry = carry_in.
  - 0<n<W: result = a<<n, carry = a[W-n].
  - n=W: result = 0, carry = a[0].
  - n>W: result = 0, carry = 0.
- LSR:
  - n=0: result = a, carry = carry_in.
  - 0<n<W: result = a>>n, carry = a[n-1].
  - n=W: result = 0, carry = a[W-1].
  - n>W: result = 0, carry = 0.
- ASR:
  - n=0: result = a, carry = carry_in.
  - 0<n<W: arithmetic shift, carry = a[n-1].
  - n≥W: every bit = a[W-1], carry = a[W-1].
- ROR:
  - n=0: result = a, carry = carry_in.
  - Otherwise r = n mod W and result = a rotated right by r.
  - carry = result[W-1]. When r=0 with n≠0 this gives result = a, carry = a[W-1].
- RRX: result = {carry_in, a[W-1:1]}, carry = a[0]; amount is ignored.
- IMMROT: r = 2·amount[3:0], taken mod W.
  - r=0: result = a, carry = carry_in.
  - Otherwise behaves as ROR by r.
  - For W=32 this matches the ARM data-processing immediate encoding.
- Reserved op codes: result = a, carry = carry_in.
- Computation split across stages:
  - Stage 1 decodes the op and saturates the amount, then applies the low half of the log2(W) mux levels.
  - The remaining levels are distributed over the later stages, as evenly as possible.
  - With STAGES=1, everything completes in one stage.

## Timing
- Latency is exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, provided out_ready stays high.
- Each stage holds a valid bit plus its payload.
- Stage k loads when it is empty, or when stage k+1 loads/drains on the same cycle.
- The last stage drains when out_valid & out_ready.
- in_ready = !v1 | (v1 & stage 2 advancing), where v1 is the stage-1 valid and the advance term is combinational down the chain.
  - Full throughput is sustained under continuous out_ready.
  - There is no bubble when a full pipeline drains and fills on the same cycle.
- Backpressure (out_ready=0): result/carry_out hold stable while out_valid=1. Upstream stages compact forward; after STAGES stalled cycles, in_ready goes 0.
- flush: all valids clear at the next edge. An input presented the same cycle is discarded. in_ready is 1 in the following cycle.
- Reset (rst_n low, at any time including mid-operation):
  - All valids = 0, out_valid = 0, result = 0, carry_out = 0 immediately.
  - Payload registers need not reset.
- Outputs are registered only. There is no combinational path from a/op/amount to result.

## Test plan
- W=32, STAGES=2: a=0x8000_0001 with LSL n=1, LSR n=32, ASR n=40 → 0x0000_0002/c=1, 0x0/c=1, 0xFFFF_FFFF/c=1. Each result appears exactly 2 cycles after acceptance.
- ROR a=0x0000_00F0, n=36 → 0x0000_000F, c=0. ROR n=32 → 0x0000_00F0, c=0. RRX a=1, carry_in=1 → 0x8000_0000, c=1.
- IMMROT a=0xFF, amount=4 → 0xFF00_0000, c=1. amount=0, carry_in=0 → 0xFF, c=0.
- Stream 8 back-to-back ops with out_ready=1: out_valid stays high for 8 consecutive cycles, results in order. Then hold out_ready=0 for 5 cycles: in_ready drops after 2 cycles, the output stays stable, and no op is lost or duplicated.
- Assert flush with 2 ops in flight plus a new input: no out_valid follows, and the next op completes normally.
- Pulse rst_n low mid-stream, asynchronous to clk: out_valid and result drop to 0 immediately, and no stale result appears after release.
- Randomised check for W=16, STAGES=3 and W=32, STAGES=1 against a reference model over all ops and amounts 0..255.

Source files
------------

// File: rtl/arm_shift_pipe_if.sv
// Handshake/data bundle for arm_shift_pipe.
// Master drives commands; slave is the shifter.
interface arm_shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amount;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output flush, in_valid, op, a, amount,
    output carry_in, out_ready,
    input  in_ready, out_valid, result,
    input  carry_out
  );

  modport slave (
    input  flush, in_valid, op, a, amount,
    input  carry_in, out_ready,
    output in_ready, out_valid, result,
    output carry_out
  );
endinterface

// File: rtl/arm_shift_pipe.sv
// Pipelined ARM barrel shifter with elastic
// valid/ready stages and shifter carry-out.
module arm_shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int AMT_W  = 8
) (
  input logic clk,
  input logic rst_n,
  arm_shift_pipe_if.slave bus
);
  localparam int L  = $clog2(WIDTH);
  localparam int L1 = (STAGES == 1) ? L
                    : (L + 1) / 2;
  localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int DW = 2 * WIDTH;
  localparam int CW = (AMT_W > L + 1) ? AMT_W
                    : L + 1;

  // first mux level owned by stage s
  function automatic int lv_lo(int s);
    if (s == 0) return 0;
    return L1 + ((L - L1) * (s - 1)) / NR;
  endfunction

  // one past the last level owned by stage s
  function automatic int lv_hi(int s);
    if (s == 0) return L1;
    return L1 + ((L - L1) * s) / NR;
  endfunction

  // funnel right-shift by the levels of stage s
  function automatic logic [DW-1:0] lvl(
    input logic [DW-1:0] d,
    input logic [L-1:0]  r,
    input int            s
  );
    logic [DW-1:0] v;
    v = d;
    for (int j = 0; j < L; j++) begin
      if (j >= lv_lo(s) && j < lv_hi(s) && r[j])
        v = v >> (1 << j);
    end
    return v;
  endfunction

  logic w_lsl, w_lsr, w_asr;
  logic w_ror, w_rrx, w_imm;
  logic [CW-1:0]  w_n;
  logic           w_zero, w_lt, w_eq;
  logic [L-1:0]   w_sh, w_shm1, w_neg;
  logic [L+4:0]   w_irx;
  logic [L-1:0]   w_ir, w_irm1;
  logic           w_sgn;

  assign w_lsl  = bus.op == 3'd0;
  assign w_lsr  = bus.op == 3'd1;
  assign w_asr  = bus.op == 3'd2;
  assign w_ror  = bus.op == 3'd3;
  assign w_rrx  = bus.op == 3'd4;
  assign w_imm  = bus.op == 3'd5;
  assign w_n    = CW'(bus.amount);
  assign w_zero = w_n == '0;
  assign w_lt   = w_n < CW'(WIDTH);
  assign w_eq   = w_n == CW'(WIDTH);
  assign w_sh   = w_n[L-1:0];
  assign w_shm1 = w_sh - L'(1);
  assign w_neg  = L'(0) - w_sh;
  assign w_irx  = (L+5)'({bus.amount[3:0], 1'b0});
  assign w_ir   = w_irx[L-1:0];
  assign w_irm1 = w_ir - L'(1);
  assign w_sgn  = bus.a[WIDTH-1];

  logic [WIDTH-1:0] w_hi, w_lo;
  logic [L-1:0]     w_r;
  logic             w_c;

  // map every op onto {hi,lo} >> r plus carry
  always_comb begin
    w_hi = '0;
    w_lo = bus.a;
    w_r  = '0;
    w_c  = bus.carry_in;
    unique case (1'b1)
      w_lsl: if (!w_zero) begin
        if (w_lt) begin
          w_hi = bus.a;
          w_lo = '0;
          w_r  = w_neg;
          w_c  = bus.a[w_neg];
        end else if (w_eq) begin
          w_lo = '0;
          w_c  = bus.a[0];
        end else begin
          w_lo = '0;
          w_c  = 1'b0;
        end
      end
      w_lsr: if (!w_zero) begin
        if (w_lt) begin
          w_r = w_sh;
          w_c = bus.a[w_shm1];
        end else if (w_eq) begin
          w_lo = '0;
          w_c  = w_sgn;
        end else begin
          w_lo = '0;
          w_c  = 1'b0;
        end
      end
      w_asr: if (!w_zero) begin
        if (w_lt) begin
          w_hi = {WIDTH{w_sgn}};
          w_r  = w_sh;
          w_c  = bus.a[w_shm1];
        end else begin
          w_lo = {WIDTH{w_sgn}};
          w_c  = w_sgn;
        end
      end
      w_ror: if (!w_zero) begin
        w_hi = bus.a;
        w_r  = w_sh;
        w_c  = bus.a[w_shm1];
      end
      w_rrx: begin
        w_hi = WIDTH'(bus.carry_in);
        w_r  = L'(1);
        w_c  = bus.a[0];
      end
      w_imm: if (w_ir != '0) begin
        w_hi = bus.a;
        w_r  = w_ir;
        w_c  = bus.a[w_irm1];
      end
      default: ;
    endcase
  end

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_c;
  logic [DW-1:0]     r_dat [STAGES];
  logic [L-1:0]      r_amt [STAGES];

  logic [STAGES:0]   w_ld;
  logic [STAGES-1:0] w_sv;
  logic [STAGES-1:0] w_nc;
  logic [DW-1:0]     w_nd [STAGES];
  logic [L-1:0]      w_na [STAGES];

  // a stage loads when empty or when its
  // successor advances in the same cycle
  always_comb begin
    w_ld = '0;
    w_ld[STAGES] = r_v[STAGES-1] & bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      w_ld[k] = !r_v[k] | w_ld[k+1];
  end

  // next payload of each stage
  always_comb begin
    w_sv[0] = bus.in_valid;
    w_nd[0] = lvl({w_hi, w_lo}, w_r, 0);
    w_na[0] = w_r;
    w_nc[0] = w_c;
    for (int k = 1; k < STAGES; k++) begin
      w_sv[k] = r_v[k-1];
      w_nd[k] = lvl(r_dat[k-1], r_amt[k-1], k);
      w_na[k] = r_amt[k-1];
      w_nc[k] = r_c[k-1];
    end
  end

  // stage valid bits; flush empties the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else if (bus.flush) begin
      r_v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (w_ld[k]) r_v[k] <= w_sv[k];
    end
  end

  // stage payloads; cleared so outputs read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_dat[k] <= '0;
        r_amt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ld[k] && w_sv[k]) begin
          r_dat[k] <= w_nd[k];
          r_amt[k] <= w_na[k];
          r_c[k]   <= w_nc[k];
        end
      end
    end
  end

  assign bus.in_ready  = w_ld[0];
  assign bus.out_valid = r_v[STAGES-1];
  assign bus.result    = r_dat[STAGES-1][WIDTH-1:0];
  assign bus.carry_out = r_c[STAGES-1];

  logic w_unused;
  assign w_unused = ^{r_dat[STAGES-1][DW-1:WIDTH],
                      r_amt[STAGES-1],
                      w_irx[L+4:L]};
endmodule

// File: tb/tb_arm_shift_pipe.sv
// Bench for arm_shift_pipe: directed checks on a
// 32b/2-stage unit plus random runs on three configs.
module tb_arm_shift_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        t_flush, t_in_valid, t_cin;
  logic        t_out_ready;
  logic [2:0]  t_op;
  logic [31:0] t_a;
  logic [7:0]  t_amt;

  arm_shift_pipe_if #(.WIDTH(32), .AMT_W(8)) ifa ();
  arm_shift_pipe_if #(.WIDTH(16), .AMT_W(8)) ifb ();
  arm_shift_pipe_if #(.WIDTH(32), .AMT_W(8)) ifc ();

  assign ifa.flush = t_flush;
  assign ifa.in_valid = t_in_valid;
  assign ifa.op = t_op;
  assign ifa.a = t_a;
  assign ifa.amount = t_amt;
  assign ifa.carry_in = t_cin;
  assign ifa.out_ready = t_out_ready;
  assign ifb.flush = t_flush;
  assign ifb.in_valid = t_in_valid;
  assign ifb.op = t_op;
  assign ifb.a = t_a[15:0];
  assign ifb.amount = t_amt;
  assign ifb.carry_in = t_cin;
  assign ifb.out_ready = t_out_ready;
  assign ifc.flush = t_flush;
  assign ifc.in_valid = t_in_valid;
  assign ifc.op = t_op;
  assign ifc.a = t_a;
  assign ifc.amount = t_amt;
  assign ifc.carry_in = t_cin;
  assign ifc.out_ready = t_out_ready;

  arm_shift_pipe #(.WIDTH(32), .STAGES(2), .AMT_W(8))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  arm_shift_pipe #(.WIDTH(16), .STAGES(3), .AMT_W(8))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  arm_shift_pipe #(.WIDTH(32), .STAGES(1), .AMT_W(8))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, want);
    end
  endtask

  // reference: {carry, result} from the ARM rules
  function automatic logic [32:0] model(
    input int w, input logic [31:0] ain,
    input logic [2:0] op, input int n,
    input logic cin);
    logic [31:0] m, a, r;
    logic c;
    int s;
    m = (w == 32) ? 32'hFFFF_FFFF
                  : ((32'h1 << w) - 32'h1);
    a = ain & m;
    r = a;
    c = cin;
    case (op)
      3'd0: if (n != 0) begin
        if (n < w) begin
          r = (a << n) & m; c = a[w-n];
        end else if (n == w) begin
          r = 0; c = a[0];
        end else begin
          r = 0; c = 0;
        end
      end
      3'd1: if (n != 0) begin
        if (n < w) begin
          r = a >> n; c = a[n-1];
        end else if (n == w) begin
          r = 0; c = a[w-1];
        end else begin
          r = 0; c = 0;
        end
      end
      3'd2: if (n != 0) begin
        s = (n < w) ? n : w;
        r = 0;
        for (int i = 0; i < w; i++)
          r[i] = (i + s < w) ? a[i+s] : a[w-1];
        c = a[s-1];
      end
      3'd3, 3'd5: begin
        s = (op == 3'd3) ? n % w
                         : (2 * (n % 16)) % w;
        if ((op == 3'd3 && n != 0) || (op == 3'd5 && s != 0)) begin
          r = 0;
          for (int i = 0; i < w; i++)
            r[i] = a[(i + s) % w];
          c = r[w-1];
        end
      end
      3'd4: begin
        r = (a >> 1) | ({31'b0, cin} << (w - 1));
        c = a[0];
      end
      default: ;
    endcase
    return {c, r};
  endfunction

  logic [32:0] qa[$], qb[$], qc[$], sq[$];

  function automatic void qpush(int k, logic [32:0] v);
    case (k)
      0: qa.push_back(v);
      1: qb.push_back(v);
      default: qc.push_back(v);
    endcase
  endfunction

  function automatic logic [32:0] qpop(int k);
    case (k)
      0: return qa.pop_front();
      1: return qb.pop_front();
      default: return qc.pop_front();
    endcase
  endfunction

  function automatic int qsz(int k);
    case (k)
      0: return qa.size();
      1: return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic logic [32:0] obs(int k);
    case (k)
      0: return {ifa.carry_out, ifa.result};
      1: return {ifb.carry_out, 16'h0, ifb.result};
      default: return {ifc.carry_out, ifc.result};
    endcase
  endfunction

  function automatic logic ovalid(int k);
    case (k)
      0: return ifa.out_valid;
      1: return ifb.out_valid;
      default: return ifc.out_valid;
    endcase
  endfunction

  function automatic logic iready(int k);
    case (k)
      0: return ifa.in_ready;
      1: return ifb.in_ready;
      default: return ifc.in_ready;
    endcase
  endfunction

  // one op on unit A, checking latency and value
  task automatic run1(input string tag,
    input logic [2:0] op, input logic [31:0] a,
    input logic [7:0] amt, input logic cin,
    input logic [31:0] er, input logic ec);
    int lat;
    @(negedge clk);
    t_in_valid = 1; t_op = op; t_a = a;
    t_amt = amt; t_cin = cin; t_out_ready = 1;
    #1 chk({tag, "_rdy"}, ifa.in_ready, 1);
    @(negedge clk);
    t_in_valid = 0;
    lat = 1;
    while (!ifa.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_res"}, ifa.result, er);
    chk({tag, "_c"}, ifa.carry_out, ec);
  endtask

  int first, last, cnt, seen;
  logic [32:0] held, v;
  int unsigned bnd[10] = '{0, 1, 8, 15, 16, 17,
                           31, 32, 33, 255};
  string nm[3] = '{"rnd_a", "rnd_b16", "rnd_c1"};

  initial begin
    rst_n = 1; t_flush = 0; t_in_valid = 0;
    t_cin = 0; t_out_ready = 1; t_op = 0;
    t_a = 0; t_amt = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_ov", ifa.out_valid, 0);
    chk("rst_res", ifa.result, 0);
    chk("rst_c", ifa.carry_out, 0);
    chk("rst_ir", ifa.in_ready, 1);
    #19 rst_n = 1;

    run1("lsl1", 3'd0, 32'h8000_0001, 8'd1, 0,
         32'h0000_0002, 1);
    run1("lsr32", 3'd1, 32'h8000_0001, 8'd32, 0,
         32'h0, 1);
    run1("asr40", 3'd2, 32'h8000_0001, 8'd40, 0,
         32'hFFFF_FFFF, 1);
    run1("ror36", 3'd3, 32'h0000_00F0, 8'd36, 1,
         32'h0000_000F, 0);
    run1("ror32", 3'd3, 32'h0000_00F0, 8'd32, 1,
         32'h0000_00F0, 0);
    run1("rrx", 3'd4, 32'h1, 8'd77, 1,
         32'h8000_0000, 1);
    run1("imm4", 3'd5, 32'hFF, 8'd4, 0,
         32'hFF00_0000, 1);
    run1("imm0", 3'd5, 32'hFF, 8'd0, 0,
         32'hFF, 0);
    run1("lsl33", 3'd0, 32'hFFFF_FFFF, 8'd33, 1,
         32'h0, 0);
    run1("rsv7", 3'd7, 32'h1234_5678, 8'd3, 1,
         32'h1234_5678, 1);

    // back-to-back stream
    first = -1; last = -1; cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      t_out_ready = 1;
      t_in_valid = (c < 8);
      t_op = 3'($urandom_range(0, 5));
      t_a = $urandom;
      t_amt = 8'($urandom);
      t_cin = 1'($urandom);
      #1;
      if (ifa.out_valid) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
        if (sq.size() == 0) chk("strm_extra", 1, 0);
        else chk("strm_res", obs(0), sq.pop_front());
      end
      if (t_in_valid) begin
        chk("strm_rdy", ifa.in_ready, 1);
        sq.push_back(model(32, t_a, t_op,
                           int'(t_amt), t_cin));
      end
    end
    chk("strm_lat", first, 2);
    chk("strm_run", last - first + 1, 8);
    chk("strm_cnt", cnt, 8);

    // backpressure from an empty pipe
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      t_out_ready = 0;
      t_in_valid = 1;
      t_op = 3'($urandom_range(0, 5));
      t_a = $urandom;
      t_amt = 8'($urandom);
      t_cin = 1'($urandom);
      #1;
      chk("bp_rdy", ifa.in_ready, (c < 2));
      if (ifa.in_ready)
        sq.push_back(model(32, t_a, t_op,
                           int'(t_amt), t_cin));
      if (c >= 2) begin
        chk("bp_ov", ifa.out_valid, 1);
        if (c == 2) begin
          held = obs(0);
          chk("bp_first", held, sq[0]);
        end else begin
          chk("bp_hold", obs(0), held);
        end
      end
    end
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      t_in_valid = 0;
      t_out_ready = 1;
      #1;
      if (ifa.out_valid) begin
        cnt++;
        if (sq.size() == 0) chk("bp_extra", 1, 0);
        else chk("bp_res", obs(0), sq.pop_front());
      end
    end
    chk("bp_cnt", cnt, 2);
    chk("bp_left", sq.size(), 0);

    // flush with two in flight plus a new input
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      t_out_ready = 0;
      t_in_valid = 1;
      t_op = 3'd0; t_a = 32'h1 << c;
      t_amt = 8'd1;
      t_flush = (c == 2);
    end
    @(negedge clk);
    t_flush = 0; t_in_valid = 0; t_out_ready = 1;
    #1;
    chk("fl_ir", ifa.in_ready, 1);
    chk("fl_ov", ifa.out_valid, 0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ifa.out_valid) seen++;
    end
    chk("fl_none", seen, 0);
    run1("fl_next", 3'd1, 32'hF000_0000, 8'd4, 0,
         32'h0F00_0000, 0);

    // asynchronous reset in mid-stream
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      t_out_ready = 1;
      t_in_valid = 1;
      t_op = 3'd3; t_a = 32'hDEAD_BEEF;
      t_amt = 8'(c + 1); t_cin = 1;
    end
    #1 chk("ar_pre", ifa.out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_ov", ifa.out_valid, 0);
    chk("ar_res", ifa.result, 0);
    chk("ar_c", ifa.carry_out, 0);
    @(negedge clk);
    t_in_valid = 0;
    #2 rst_n = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ifa.out_valid) seen++;
    end
    chk("ar_stale", seen, 0);

    // random traffic on all three configs
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      t_in_valid = ($urandom_range(0, 3) != 0);
      t_op = 3'($urandom);
      t_a = $urandom;
      if ($urandom_range(0, 1) == 1)
        t_amt = 8'(bnd[$urandom_range(0, 9)]);
      else
        t_amt = 8'($urandom);
      t_cin = 1'($urandom);
      t_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (ovalid(k) && t_out_ready) begin
          if (qsz(k) == 0) chk({nm[k], "_x"}, 1, 0);
          else chk(nm[k], obs(k), qpop(k));
        end
        if (t_in_valid && iready(k)) begin
          v = model((k == 1) ? 16 : 32, t_a, t_op,
                    int'(t_amt), t_cin);
          qpush(k, v);
        end
      end
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      t_in_valid = 0;
      t_out_ready = 1;
      #1;
      for (int k = 0; k < 3; k++) begin
        if (ovalid(k)) begin
          if (qsz(k) == 0) chk({nm[k], "_x"}, 1, 0);
          else chk(nm[k], obs(k), qpop(k));
        end
      end
    end
    for (int k = 0; k < 3; k++)
      chk({nm[k], "_left"}, qsz(k), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
